ifid_queue: RTL and testbench

Parametrised instruction fetch/decode unit: a successor to the single-shot fetch/decode controller. Holds the program memory, streams instructions from a fetch pointer into a small prefetch queue, and presents decoded opcode/immediate fields to the execute sequencer over a valid/ack handshake. Sits between the program loader (write port) and the execute stage. Adds continuous fetch, back-pressure, pause, flush/redirect and end-of-program detection.

---
 rtl/ifidc_pkg.sv | 31 +++
 rtl/inst_fifo.sv | 62 ++++++
 rtl/ifid_queue.sv | 119 +++++++++++
 tb/tb_ifid_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifidc_pkg.sv
// Shared definitions for the instruction fetch/decode queue: FSM state
// encoding, NOP opcode, and opcode/immediate field extraction helpers.
// Helpers work on words up to FIELD_W bits; callers truncate to their widths.
package ifidc_pkg;

   localparam int unsigned FIELD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   // NOP opcode: MSB of the opcode field set, all other bits clear
   function automatic logic [FIELD_W-1:0] nop_op(input int unsigned op_len);
      return FIELD_W'(1) << (op_len - 1);
   endfunction

   // Opcode lives in the bits above the immediate field
   function automatic logic [FIELD_W-1:0] op_field(input logic [FIELD_W-1:0] word,
                                                   input int unsigned data_len);
      return word >> data_len;
   endfunction

   // Immediate/address field is the low data_len bits
   function automatic logic [FIELD_W-1:0] imm_field(input logic [FIELD_W-1:0] word,
                                                    input int unsigned data_len);
      return word & ((FIELD_W'(1) << data_len) - FIELD_W'(1));
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO for fetched {word, address} entries.
// Ports: clk, rstn (async active-low), clear (sync flush), push/push_data,
// pop; head (oldest entry), count, full, empty. Push while full is accepted
// when a pop happens in the same cycle; clear wins over push and pop.
module inst_fifo #(
   parameter  int unsigned WIDTH = 18,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] slot [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slot[rd_ptr];

   // Pointer and occupancy state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Entry storage; contents only matter while counted as occupied
   always_ff @(posedge clk) begin
      if (do_push && !clear) slot[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifid_queue.sv
// Instruction fetch/decode unit: program memory, fetch pointer, prefetch
// queue and head decode. Ports: clk, rstn; en (fetch enable), flush + pc
// (redirect), wr_en/wr_addr/wr_data (program load), IS_ack (consumer accept);
// IS_ready, control_bus, data, fetch_pc (head instruction), done (program
// exhausted and queue drained). Outputs derive only from flops.
module ifid_queue
   import ifidc_pkg::*;
#(
   parameter  int unsigned INST_CAP = 20,
   parameter  int unsigned INST_LEN = 12,
   parameter  int unsigned DATA_LEN = 8,
   parameter  int unsigned QDEPTH   = 2,
   parameter  int unsigned PC_W     = $clog2(INST_CAP) + 1,
   localparam int unsigned OP_LEN   = INST_LEN - DATA_LEN
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   input  logic                flush,
   input  logic [PC_W-1:0]     pc,
   input  logic                wr_en,
   input  logic [PC_W-1:0]     wr_addr,
   input  logic [INST_LEN-1:0] wr_data,
   input  logic                IS_ack,
   output logic                IS_ready,
   output logic [OP_LEN-1:0]   control_bus,
   output logic [DATA_LEN-1:0] data,
   output logic [PC_W-1:0]     fetch_pc,
   output logic                done
);

   localparam int unsigned AW    = $clog2(INST_CAP);
   localparam int unsigned QW    = INST_LEN + PC_W;
   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

   logic [INST_LEN-1:0] mem [INST_CAP];
   state_e              state_q, state_d;
   logic [PC_W-1:0]     fptr_q, fptr_d;
   logic                q_clear, q_push, q_pop;
   logic [QW-1:0]       q_head;
   logic [CNT_W-1:0]    q_count;
   logic                q_full, q_empty;
   logic                in_range;
   logic [INST_LEN-1:0] head_word;

   assign in_range = (fptr_q < PC_W'(INST_CAP));

   // Program memory: write at the edge, so a same-edge fetch sees the old word
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < PC_W'(INST_CAP))) mem[wr_addr[AW-1:0]] <= wr_data;
   end

   // State and fetch pointer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         fptr_q  <= '0;
      end else begin
         state_q <= state_d;
         fptr_q  <= fptr_d;
      end
   end

   // Next state, fetch and queue control; flush overrides both queue ports
   always_comb begin
      state_d = state_q;
      fptr_d  = fptr_q;
      q_clear = 1'b0;
      q_push  = 1'b0;
      q_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_RUN;
               fptr_d  = pc;
               q_clear = 1'b1;
            end
         end
         ST_RUN, ST_PAUSE: begin
            state_d = en ? ST_RUN : ST_PAUSE;
            if (flush) begin
               q_clear = 1'b1;
               fptr_d  = pc;
            end else begin
               q_pop  = IS_ack && !q_empty;
               q_push = (state_q == ST_RUN) && in_range && (!q_full || q_pop);
               if (q_push) fptr_d = fptr_q + PC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   inst_fifo #(
      .WIDTH (QW),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (q_clear),
      .push      (q_push),
      .push_data ({mem[fptr_q[AW-1:0]], fptr_q}),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   // Head decode; empty queue presents a NOP with zeroed fields
   assign head_word   = q_head[QW-1:PC_W];
   assign IS_ready    = !q_empty;
   assign control_bus = q_empty ? OP_LEN'(nop_op(OP_LEN))
                                : OP_LEN'(op_field(FIELD_W'(head_word), DATA_LEN));
   assign data        = q_empty ? '0 : DATA_LEN'(imm_field(FIELD_W'(head_word), DATA_LEN));
   assign fetch_pc    = q_empty ? '0 : q_head[PC_W-1:0];
   assign done        = (state_q != ST_IDLE) && !in_range && (q_count == '0);

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_ifid_queue;

   localparam int unsigned CAP = 20;
   localparam int unsigned IL  = 12;
   localparam int unsigned DL  = 8;
   localparam int unsigned QD  = 2;
   localparam int unsigned PW  = 6;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          en = 1'b0, flush = 1'b0, wr_en = 1'b0, IS_ack = 1'b0;
   logic [PW-1:0] pc = '0, wr_addr = '0;
   logic [IL-1:0] wr_data = '0;
   logic          IS_ready, done;
   logic [3:0]    control_bus;
   logic [7:0]    data;
   logic [PW-1:0] fetch_pc;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [IL-1:0]    mm [CAP];
   logic [IL+PW-1:0] q [$];
   int               fp = 0;
   bit               started = 0;
   bit               running = 0;

   ifid_queue #(.INST_CAP(CAP), .INST_LEN(IL), .DATA_LEN(DL), .QDEPTH(QD), .PC_W(PW)) dut (
      .clk(clk), .rstn(rstn), .en(en), .flush(flush), .pc(pc),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .IS_ack(IS_ack),
      .IS_ready(IS_ready), .control_bus(control_bus), .data(data),
      .fetch_pc(fetch_pc), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare all outputs with the model's view of the queue head
   task automatic check_all(input string tag);
      logic [IL-1:0] w;
      logic [PW-1:0] a;
      bit            r;
      r = (q.size() != 0);
      w = '0;
      a = '0;
      if (r) {w, a} = q[0];
      check({tag, ".rdy"},  32'(IS_ready),    32'(r));
      check({tag, ".op"},   32'(control_bus), r ? 32'(w[IL-1:DL]) : 32'h8);
      check({tag, ".imm"},  32'(data),        r ? 32'(w[DL-1:0]) : 32'h0);
      check({tag, ".pc"},   32'(fetch_pc),    r ? 32'(a) : 32'h0);
      check({tag, ".done"}, 32'(done),        32'(started && fp >= int'(CAP) && q.size() == 0));
   endtask

   // Model one clock edge from the rules: flush discards, else dequeue on
   // ack, fetch while running with a free slot; memory write lands last
   task automatic model_edge();
      bit deq, enq;
      if (!started) begin
         if (en) begin
            started = 1;
            running = 1;
            fp = int'(pc);
            q.delete();
         end
      end else begin
         if (flush) begin
            q.delete();
            fp = int'(pc);
         end else begin
            deq = (q.size() != 0) && IS_ack;
            enq = running && fp < int'(CAP) && (q.size() < int'(QD) || deq);
            if (deq) void'(q.pop_front());
            if (enq) begin
               q.push_back({mm[fp], PW'(fp)});
               fp++;
            end
         end
         running = en;
      end
      if (wr_en && int'(wr_addr) < int'(CAP)) mm[wr_addr] = wr_data;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all("cyc");
   endtask

   // Asynchronous reset between clock edges; memory content survives
   task automatic do_reset();
      #2 rstn = 1'b0;
      started = 0;
      running = 0;
      fp = 0;
      q.delete();
      #1 check_all("rst");
      @(negedge clk);
      rstn = 1'b1;
   endtask

   logic [IL-1:0] old_w;

   initial begin
      do_reset();

      // Program load
      for (int a = 0; a < int'(CAP); a++) begin
         wr_en = 1'b1;
         wr_addr = PW'(a);
         wr_data = IL'($urandom);
         if (a == 0) wr_data = 12'h105;
         if (a == 1) wr_data = 12'h2A0;
         if (a == 2) wr_data = 12'h3FF;
         if (a == 10) wr_data = 12'h4C3;
         step();
      end
      wr_en = 1'b0;

      // Basic stream: IS_ready two cycles after en
      en = 1'b1; pc = '0; IS_ack = 1'b1;
      step(); check("lat.rdy0", 32'(IS_ready), 32'h0);
      step(); check("s0.op", 32'(control_bus), 32'h1); check("s0.imm", 32'(data), 32'h05);
              check("s0.pc", 32'(fetch_pc), 32'h0);
      step(); check("s1.op", 32'(control_bus), 32'h2); check("s1.imm", 32'(data), 32'hA0);
              check("s1.pc", 32'(fetch_pc), 32'h1);
      step(); check("s2.op", 32'(control_bus), 32'h3); check("s2.imm", 32'(data), 32'hFF);
              check("s2.pc", 32'(fetch_pc), 32'h2);

      // Flush to 10 mid-stream
      step();
      flush = 1'b1; pc = PW'(10);
      step(); check("fl.rdy0", 32'(IS_ready), 32'h0);
      flush = 1'b0;
      step(); check("fl.op", 32'(control_bus), 32'h4); check("fl.imm", 32'(data), 32'hC3);
              check("fl.pc", 32'(fetch_pc), 32'd10);

      // Back-pressure: head holds while queue stays full
      do_reset();
      en = 1'b1; pc = '0; IS_ack = 1'b0;
      repeat (7) step();
      check("bp.rdy", 32'(IS_ready), 32'h1); check("bp.op", 32'(control_bus), 32'h1);
      check("bp.pc", 32'(fetch_pc), 32'h0);
      IS_ack = 1'b1;
      step(); check("bp.pc1", 32'(fetch_pc), 32'h1);
      step(); check("bp.pc2", 32'(fetch_pc), 32'h2);
      step(); check("bp.pc3", 32'(fetch_pc), 32'h3);

      // Pause: drain, then resume at the next pointer without reload
      do_reset();
      en = 1'b1; pc = '0; IS_ack = 1'b0;
      step(); step();
      en = 1'b0; pc = PW'(15);
      step();
      IS_ack = 1'b1;
      repeat (4) step();
      check("pz.empty", 32'(IS_ready), 32'h0);
      en = 1'b1;
      step(); step();
      check("pz.rdy", 32'(IS_ready), 32'h1); check("pz.pc", 32'(fetch_pc), 32'h2);

      // End of memory from pc=18
      do_reset();
      en = 1'b1; pc = PW'(18); IS_ack = 1'b1;
      step(); step(); check("em.pc18", 32'(fetch_pc), 32'd18);
      step(); check("em.pc19", 32'(fetch_pc), 32'd19); check("em.nd", 32'(done), 32'h0);
      step(); check("em.done", 32'(done), 32'h1); check("em.rdy", 32'(IS_ready), 32'h0);

      // Start beyond memory: done with nothing presented
      do_reset();
      pc = PW'(25);
      step(); step();
      check("ob.done", 32'(done), 32'h1); check("ob.rdy", 32'(IS_ready), 32'h0);

      // Async reset with an instruction presented
      do_reset();
      pc = '0; IS_ack = 1'b0;
      repeat (3) step();
      check("ar.pre", 32'(IS_ready), 32'h1);
      do_reset();
      check("ar.rdy", 32'(IS_ready), 32'h0); check("ar.op", 32'(control_bus), 32'h8);
      check("ar.imm", 32'(data), 32'h0);

      // Same-edge write and fetch of one address returns the old word
      pc = PW'(5);
      step();
      old_w = mm[5];
      wr_en = 1'b1; wr_addr = PW'(5); wr_data = ~old_w;
      step();
      wr_en = 1'b0;
      check("rw.op", 32'(control_bus), 32'(old_w[IL-1:DL]));
      check("rw.imm", 32'(data), 32'(old_w[DL-1:0]));
      step();

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         en      = ($urandom_range(9) != 0);
         flush   = ($urandom_range(19) == 0);
         pc      = PW'($urandom_range(24));
         IS_ack  = ($urandom_range(2) != 0);
         wr_en   = ($urandom_range(7) == 0);
         wr_addr = PW'($urandom_range(31));
         wr_data = IL'($urandom);
         if ($urandom_range(499) == 0) do_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
